// File: rtl/bullet_plotter_pkg.sv
`default_nettype none
// bullet_plotter_pkg: screen geometry, colours, history entry type and plotter state encoding.
// Rev 1.0
package bullet_plotter_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] FG_COLOUR = 3'b111;
  localparam logic [2:0] BG_COLOUR = 3'b000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_COMPARE = 3'd2;
  localparam logic [2:0] ST_ERASE   = 3'd3;
  localparam logic [2:0] ST_DRAW    = 3'd4;
  localparam logic [2:0] ST_FINISH  = 3'd5;

  typedef struct packed {
    logic           valid;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } hist_entry_t;

endpackage
`default_nettype wire

// File: rtl/bullet_history.sv
`default_nettype none
// bullet_history: per-slot record of the last drawn pixel; sync write, async read, sync clear.
// Rev 1.0
module bullet_history
  import bullet_plotter_pkg::*;
#(
  parameter int NUM_BULLETS = 160,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] idx,
  input  logic             wr_en,
  input  hist_entry_t      wr_entry,
  output hist_entry_t      rd_entry
);

  hist_entry_t entries [NUM_BULLETS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        entries[i] <= '0;
      end
    end else if (wr_en) begin
      entries[idx] <= wr_entry;
    end
  end

  assign rd_entry = entries[idx];

endmodule
`default_nettype wire

// File: rtl/bullet_plotter.sv
`default_nettype none
// bullet_plotter: once per frame, walks every bullet slot and erases/draws only changed pixels.
// Rev 1.0
module bullet_plotter #(
  parameter int         NUM_BULLETS = 160,
  parameter int         IDX_W       = 8,
  parameter int         SCREEN_W    = bullet_plotter_pkg::SCREEN_W,
  parameter int         SCREEN_H    = bullet_plotter_pkg::SCREEN_H,
  parameter logic [2:0] FG_COLOUR   = bullet_plotter_pkg::FG_COLOUR,
  parameter logic [2:0] BG_COLOUR   = bullet_plotter_pkg::BG_COLOUR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [7:0]       rd_x,
  input  logic [6:0]       rd_y,
  input  logic             rd_active,
  output logic [7:0]       vga_x,
  output logic [6:0]       vga_y,
  output logic [2:0]       vga_colour,
  output logic             vga_plot,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  import bullet_plotter_pkg::*;

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic             need_draw_q;
  logic [7:0]       old_x, new_x;
  logic [6:0]       old_y, new_y;

  hist_entry_t prev, wr_entry;
  logic        act, moved, need_erase, need_draw, last, advance;

  bullet_history #(
    .NUM_BULLETS (NUM_BULLETS),
    .IDX_W       (IDX_W)
  ) u_history (
    .clk      (clk),
    .reset    (reset),
    .idx      (idx),
    .wr_en    (state == ST_COMPARE),
    .wr_entry (wr_entry),
    .rd_entry (prev)
  );

  // Off-screen bullets are treated exactly like inactive ones.
  always_comb begin
    act        = rd_active && (32'(rd_x) < 32'(SCREEN_W)) && (32'(rd_y) < 32'(SCREEN_H));
    moved      = (rd_x != prev.x) || (rd_y != prev.y);
    need_erase = prev.valid && (!act || moved);
    need_draw  = act && (!prev.valid || moved);
    wr_entry   = '{valid: act, x: rd_x, y: rd_y};
  end

  assign last    = (idx == IDX_W'(NUM_BULLETS - 1));
  assign advance = ((state == ST_COMPARE) && !need_erase && !need_draw) ||
                   ((state == ST_ERASE) && !need_draw_q) ||
                   (state == ST_DRAW);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      need_draw_q <= 1'b0;
      old_x       <= '0;
      old_y       <= '0;
      new_x       <= '0;
      new_y       <= '0;
    end else if (advance) begin
      state <= last ? ST_FINISH : ST_FETCH;
      if (!last) idx <= idx + 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            idx   <= '0;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_COMPARE;
        ST_COMPARE: begin
          need_draw_q <= need_draw;
          old_x       <= prev.x;
          old_y       <= prev.y;
          new_x       <= rd_x;
          new_y       <= rd_y;
          state       <= need_erase ? ST_ERASE : ST_DRAW;
        end
        ST_ERASE:  state <= ST_DRAW;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign rd_idx     = idx;
  assign vga_plot   = (state == ST_ERASE) || (state == ST_DRAW);
  assign vga_x      = (state == ST_ERASE) ? old_x : new_x;
  assign vga_y      = (state == ST_ERASE) ? old_y : new_y;
  assign vga_colour = (state == ST_DRAW) ? FG_COLOUR : BG_COLOUR;
  assign busy       = (state == ST_FETCH) || (state == ST_COMPARE) || vga_plot;
  assign done       = (state == ST_FINISH);
  assign overrun    = frame_tick && (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bullet_plotter.sv
`default_nettype none
// tb_bullet_plotter: directed passes checked against a slot-level erase/draw model.
module tb_bullet_plotter;

  localparam int N = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] rd_idx;
  logic [7:0] rd_x = '0;
  logic [6:0] rd_y = '0;
  logic       rd_active = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done, overrun;

  bullet_plotter dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .rd_idx     (rd_idx),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_active  (rd_active),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Bullet pool: registered read, data valid one cycle after the index.
  logic [7:0] pool_x   [N];
  logic [6:0] pool_y   [N];
  logic       pool_act [N];

  always @(posedge clk) begin
    rd_x      <= pool_x[rd_idx];
    rd_y      <= pool_y[rd_idx];
    rd_active <= pool_act[rd_idx];
  end

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         t;
  } pix_t;

  logic       mh_v [N];
  logic [7:0] mh_x [N];
  logic [6:0] mh_y [N];

  pix_t exp_q[$];
  pix_t log_q[$];
  pix_t cmp_e;
  int   tests = 0, fails = 0, cyc = 0, ovr_cnt = 0, last_cycles = 0, log_base = 0;

  function automatic void check(string name, int actual, int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (overrun) ovr_cnt++;
      if (vga_plot) begin
        log_q.push_back('{vga_x, vga_y, vga_colour, cyc});
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_plot: got (%0d,%0d) colour %0d, expected no write",
                   vga_x, vga_y, vga_colour);
        end else begin
          cmp_e = exp_q.pop_front();
          check("plot_x", int'(vga_x), int'(cmp_e.x));
          check("plot_y", int'(vga_y), int'(cmp_e.y));
          check("plot_colour", int'(vga_colour), int'(cmp_e.c));
        end
      end
    end
  end

  // Expected writes for one pass in slot order; returns the tick-to-done cycle count.
  function automatic int model_pass();
    int nw = 0;
    for (int i = 0; i < N; i++) begin
      bit act   = pool_act[i] && (pool_x[i] < 160) && (pool_y[i] < 120);
      bit moved = (pool_x[i] != mh_x[i]) || (pool_y[i] != mh_y[i]);
      if (mh_v[i] && (!act || moved)) begin
        exp_q.push_back('{mh_x[i], mh_y[i], 3'b000, 0});
        nw++;
      end
      if (act && (!mh_v[i] || moved)) begin
        exp_q.push_back('{pool_x[i], pool_y[i], 3'b111, 0});
        nw++;
      end
      mh_v[i] = act;
      mh_x[i] = pool_x[i];
      mh_y[i] = pool_y[i];
    end
    return 2 * N + 1 + nw;
  endfunction

  // mode 0: plain pass; 1: extra tick mid-pass; 2: extra tick in the done cycle.
  task automatic run_pass(input int mode);
    int exp_cycles, count, inj, ovr_base;
    log_base   = log_q.size();
    ovr_base   = ovr_cnt;
    exp_cycles = model_pass();
    inj        = (mode == 1) ? 7 : (mode == 2) ? exp_cycles : -1;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    count = 1;
    check("busy_after_tick", int'(busy), 1);
    forever begin
      frame_tick = (count == inj);
      if (done || count > exp_cycles + 8) break;
      @(posedge clk); #1;
      count++;
    end
    check("done_cycle", count, exp_cycles);
    last_cycles = count;
    if (frame_tick) begin
      @(posedge clk); #1 frame_tick = 1'b0;
      check("busy_after_finish_tick", int'(busy), 0);
    end
    @(posedge clk); #1;
    check("done_single_pulse", int'(done), 0);
    check("idle_after_pass", int'(busy), 0);
    check("missing_plots", exp_q.size(), 0);
    check("overrun_count", ovr_cnt - ovr_base, (mode == 0) ? 0 : 1);
  endtask

  task automatic reset_mid_pass();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("busy_after_reset", int'(busy), 0);
    check("plot_after_reset", int'(vga_plot), 0);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      mh_v[i] = 1'b0;
      mh_x[i] = '0;
      mh_y[i] = '0;
    end
  endtask

  task automatic check_log(input string name, input int k, input int x, input int y, input int c);
    if (log_base + k >= log_q.size()) begin
      tests++;
      fails++;
      $display("FAIL %s: got no write #%0d, expected (%0d,%0d) colour %0d", name, k, x, y, c);
    end else begin
      check({name, "_x"}, int'(log_q[log_base+k].x), x);
      check({name, "_y"}, int'(log_q[log_base+k].y), y);
      check({name, "_c"}, int'(log_q[log_base+k].c), c);
    end
  endtask

  function automatic int pass_writes();
    return log_q.size() - log_base;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      pool_x[i] = '0; pool_y[i] = '0; pool_act[i] = 1'b0;
      mh_v[i] = 1'b0; mh_x[i] = '0; mh_y[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_plot", int'(vga_plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_rd_idx", int'(rd_idx), 0);
    check("rst_colour", int'(vga_colour), 0);
    reset = 1'b0;

    run_pass(0);
    check("empty_cycles", last_cycles, 321);
    check("empty_writes", pass_writes(), 0);

    pool_act[3] = 1'b1; pool_x[3] = 8'd10; pool_y[3] = 7'd20;
    run_pass(0);
    check("first_draw_n", pass_writes(), 1);
    check_log("first_draw", 0, 10, 20, 7);
    check("first_draw_cycles", last_cycles, 322);

    run_pass(0);
    check("static_n", pass_writes(), 0);

    pool_x[3] = 8'd11;
    run_pass(0);
    check("move_n", pass_writes(), 2);
    check_log("move_erase", 0, 10, 20, 0);
    check_log("move_draw", 1, 11, 20, 7);
    if (pass_writes() == 2)
      check("move_adjacent", log_q[log_base+1].t - log_q[log_base].t, 1);

    pool_act[3] = 1'b0;
    run_pass(0);
    check("deact_n", pass_writes(), 1);
    check_log("deact_erase", 0, 11, 20, 0);
    run_pass(0);
    check("deact_again_n", pass_writes(), 0);

    pool_act[5] = 1'b1; pool_x[5] = 8'd160; pool_y[5] = 7'd50;
    run_pass(0);
    check("offscreen_x_n", pass_writes(), 0);
    pool_x[5] = 8'd40; pool_y[5] = 7'd120;
    run_pass(0);
    check("offscreen_y_n", pass_writes(), 0);
    pool_y[5] = 7'd50;
    run_pass(0);
    check("onscreen_n", pass_writes(), 1);
    check_log("onscreen_draw", 0, 40, 50, 7);

    pool_act[5] = 1'b0;
    run_pass(1);
    check("overrun_pass_n", pass_writes(), 1);
    check_log("overrun_erase", 0, 40, 50, 0);
    run_pass(2);
    check("finish_tick_n", pass_writes(), 0);

    pool_act[3]   = 1'b1; pool_x[3]   = 8'd1;   pool_y[3]   = 7'd1;
    pool_act[100] = 1'b1; pool_x[100] = 8'd50;  pool_y[100] = 7'd60;
    pool_act[159] = 1'b1; pool_x[159] = 8'd159; pool_y[159] = 7'd119;
    run_pass(0);
    check("three_n", pass_writes(), 3);
    check_log("edge_draw", 2, 159, 119, 7);
    reset_mid_pass();
    run_pass(0);
    check("redraw_n", pass_writes(), 3);
    check("redraw_cycles", last_cycles, 324);
    check_log("redraw_first", 0, 1, 1, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bullet_plotter.md
Name: bullet_plotter

Overview:
- Downstream of the bullet pool. Once per frame it walks every bullet slot and reads each slot's current position and plot flag. It erases the pixel the bullet occupied last frame and draws its new pixel.
- Its write port drives the 160x120 VGA adapter's pixel write interface (x, y, colour, plot).
- It keeps a per-slot copy of the last drawn position, so only changed pixels are written.

Parameters:
- NUM_BULLETS, 160, number of bullet slots scanned per pass
- IDX_W, 8, slot index width; must satisfy 2**IDX_W >= NUM_BULLETS
- SCREEN_W, 160, horizontal resolution; valid x is 0..SCREEN_W-1
- SCREEN_H, 120, vertical resolution; valid y is 0..SCREEN_H-1
- FG_COLOUR, 3'b111, bullet colour
- BG_COLOUR, 3'b000, erase colour

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse; starts a pass
- rd_idx  out  IDX_W  slot index presented to the bullet pool
- rd_x  in  8  slot x; valid exactly 1 cycle after rd_idx is presented
- rd_y  in  7  slot y; same timing as rd_x
- rd_active  in  1  slot plot flag; same timing as rd_x
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  pixel write strobe, one pixel per cycle
- busy  out  1  high while a pass is in progress
- done  out  1  one-cycle pulse in the cycle the pass ends
- overrun  out  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Reset values:
  - All outputs 0, except vga_colour = BG_COLOUR.
  - State = IDLE, slot counter = 0.
  - Every prev_valid bit in the history table = 0; prev_x and prev_y = 0.
- History table: NUM_BULLETS entries of {prev_valid, prev_x[7:0], prev_y[6:0]}, held in flops.
- States: IDLE, FETCH, COMPARE, ERASE, DRAW, FINISH.
- IDLE:
  - On frame_tick, load idx = 0 and go to FETCH.
  - busy goes high in the FETCH cycle.
- FETCH:
  - rd_idx = idx; go to COMPARE.
- COMPARE (rd_* valid this cycle):
  - act = rd_active && rd_x < SCREEN_W && rd_y < SCREEN_H. Off-screen bullets count as inactive.
  - moved = (rd_x != prev_x) || (rd_y != prev_y).
  - need_erase = prev_valid && (!act || moved).
  - need_draw = act && (!prev_valid || moved).
  - Latch rd_x and rd_y. Write back the history entry as {act, rd_x, rd_y}.
  - Next state: ERASE if need_erase; else DRAW if need_draw; else advance.
- ERASE:
  - vga_plot = 1 at the old position, vga_colour = BG_COLOUR.
  - Next state: DRAW if need_draw, else advance.
- DRAW:
  - vga_plot = 1 at the latched position, vga_colour = FG_COLOUR.
  - Then advance.
- Advance:
  - If idx == NUM_BULLETS-1, go to FINISH.
  - Otherwise idx + 1, go to FETCH.
- FINISH:
  - done = 1 for one cycle, busy = 0, go to IDLE.
- Per-slot cost is 2 to 4 cycles. A full pass takes 2*NUM_BULLETS+1 to 4*NUM_BULLETS+1 cycles.
- vga_plot is low in every state other than ERASE and DRAW. vga_x, vga_y and vga_colour are don't-care while vga_plot = 0.
- frame_tick while busy: the tick is ignored, overrun pulses, and the current pass continues.
- frame_tick in the same cycle as FINISH: the tick is ignored and overrun pulses. The next pass starts only from IDLE.
- Reset mid-pass:
  - Takes effect in the next cycle and aborts the pass.
  - No erase is performed and the history table is cleared.
  - Pixels already on screen stay there; the host redraws the background.
- Unchanged active bullet: no pixel writes.
- A slot that becomes inactive is erased exactly once.

Decomposition:
- Shared package holds:
  - SCREEN_W, SCREEN_H, FG_COLOUR, BG_COLOUR.
  - The x/y width constants (8 and 7).
  - The state enumeration encoding.
- One natural sub-module: bullet_history, the NUM_BULLETS-entry table.
  - One synchronous write port and one combinational read port, both addressed by idx.
  - Synchronous clear on reset.

Test Plan:
- Reset, then a pass with all slots inactive -> no vga_plot; done asserts exactly 2*NUM_BULLETS+1 cycles after frame_tick.
- Slot 3 active at (10,20) on the first pass -> a single write at (10,20) with colour 3'b111. Second pass with the same position -> no writes.
- Slot 3 moves to (11,20) -> write (10,20) with 3'b000, then (11,20) with 3'b111 on the next cycle; the history entry then holds (11,20).
- Slot 3 goes inactive -> one write at (11,20) with 3'b000. A further pass -> no writes.
- Slot 5 active at (160,50) or (40,120) -> no writes; history shows the entry invalid.
- Second frame_tick mid-pass -> overrun pulses once and the pass completes unchanged. Reset mid-pass -> busy = 0 next cycle, and the next pass redraws every active slot.
